// File: rtl/reset_conditioner.sv
// reset_conditioner: merges pin, debounced button and software resets into a held, sync-released rst_n_o
module reset_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       sw_rst_req,
  output logic       rst_n_o,
  output logic       busy_o,
  output logic [1:0] cause_o,
  output logic [7:0] rst_count_o
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {ASSERT, HOLD, RUN} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] rsync, bsync;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic rst_int, bs, db, btn_press, event_hit;
  assign rst_int = rsync[SYNC_STAGES-1];
  assign bs = bsync[SYNC_STAGES-1];
  assign btn_press = bs && !db && dcnt == DMAX;
  assign busy_o = state != RUN;
  assign event_hit = state != ASSERT && nxt == ASSERT;
  always_ff @(posedge clk or posedge rst)
    if (rst) rsync <= '1;
    else rsync <= {rsync[SYNC_STAGES-2:0], 1'b0};
  always_ff @(posedge clk or posedge rst_int)
    if (rst_int) begin
      bsync <= '0;
      db <= 1'b0;
      dcnt <= '0;
    end else begin
      bsync <= {bsync[SYNC_STAGES-2:0], btn_in};
      if (bs == db) dcnt <= '0;
      else if (dcnt == DMAX) begin
        db <= ~db;
        dcnt <= '0;
      end else dcnt <= dcnt + DW'(1);
    end
  // a press seen in ASSERT keeps us there: the debounced level goes high on this edge
  always_comb begin
    nxt = state;
    case (state)
      ASSERT: nxt = (!db && !sw_rst_req && !btn_press) ? HOLD : ASSERT;
      HOLD: nxt = btn_press ? ASSERT : (hcnt == HMAX) ? RUN : HOLD;
      RUN: nxt = (btn_press || sw_rst_req) ? ASSERT : RUN;
      default: nxt = ASSERT;
    endcase
  end
  always_ff @(posedge clk or posedge rst_int)
    if (rst_int) begin
      state <= ASSERT;
      hcnt <= '0;
      rst_n_o <= 1'b0;
      cause_o <= 2'b00;
      rst_count_o <= 8'd0;
    end else begin
      state <= nxt;
      hcnt <= (state == HOLD && nxt == HOLD) ? hcnt + HW'(1) : '0;
      rst_n_o <= nxt == RUN;
      if (event_hit) begin
        cause_o <= btn_press ? 2'b01 : 2'b10;
        rst_count_o <= rst_count_o != 8'hff ? rst_count_o + 8'd1 : rst_count_o;
      end
    end
endmodule

// File: doc/reset_conditioner.md
Name: reset_conditioner

Overview:
- Conditions every reset source for the soft-core system and drives the active-low system reset consumed by processorci_top.
- Sits between the board pins / debug control and the processor wrapper.
- Merges three reset sources:
  - the asynchronous pin reset;
  - a debounced push-button reset;
  - a software/debug reset request.
- Guarantees a minimum hold time, asynchronous assertion and synchronous release, and records the cause and count of reset events.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for rst release and btn_in; legal range >=2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced button level changes; >=1.
- HOLD_CYCLES, 20: cycles rst_n_o stays low after all reset sources are released; >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset (pin).
- btn_in  in  1  raw push-button, active-high, asynchronous to clk.
- sw_rst_req  in  1  synchronous level request from debug/SPI control; high requests reset.
- rst_n_o  out  1  conditioned system reset, active-low, registered.
- busy_o  out  1  high while not in RUN.
- cause_o  out  2  last reset cause: 00 pin/power-on, 01 button, 10 software.
- rst_count_o  out  8  number of button/software reset events since last rst, saturating.

Behaviour:
- Internal reset rst_int:
  - Asserts asynchronously with rst.
  - Deasserts through a SYNC_STAGES flop chain preloaded to 1.
  - All other state is asynchronously reset by rst_int.
- Reset values: rst_n_o=0, busy_o=1, cause_o=00, rst_count_o=0, state=ASSERT, hold counter=0, debounced level=0, debounce counter=0.
- rst assertion at any time, including mid-HOLD or in RUN:
  - rst_n_o drops to 0 combinationally-async, with no clock required.
  - All registers return to their reset values.
- Button path:
  - btn_in passes through SYNC_STAGES flops.
  - The debounce counter clears whenever the synchronized value equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the input is still different, the debounced level toggles on that edge and the counter clears.
  - btn_press is a one-cycle pulse on a debounced 0->1 transition.
- FSM states:
  - ASSERT:
    - rst_n_o=0.
    - Leaves for HOLD, with counter=0, on the first edge where the debounced level=0 and sw_rst_req=0.
  - HOLD:
    - rst_n_o=0; the counter increments each cycle.
    - When counter==HOLD_CYCLES-1, goes to RUN on that edge.
    - btn_press in HOLD -> ASSERT (counts as a new event).
    - sw_rst_req is ignored in HOLD.
  - RUN:
    - rst_n_o=1.
    - btn_press or sw_rst_req=1 -> ASSERT on that edge; rst_n_o=0 from that edge.
- rst_n_o is registered from the next-state value (rst_n_o = next_state==RUN), so it toggles on the same edge as the state change.
- Pin-release latency: with rst falling before edge 1 and button/software idle:
  - rst_int is low after edge SYNC_STAGES.
  - HOLD is entered at edge SYNC_STAGES+1.
  - rst_n_o rises at edge SYNC_STAGES+HOLD_CYCLES+1 (23 with defaults).
- Event bookkeeping, applied on each entry to ASSERT from RUN or HOLD:
  - rst_count_o increments, saturating at 255 (255 stays 255).
  - cause_o = 01 if btn_press, else 10.
  - If btn_press and sw_rst_req occur in the same cycle in RUN, the button has priority: cause 01, count +1 only once.
  - Pin reset clears the count and sets cause 00. Button/software resets do not clear them.
- busy_o = (registered state != RUN).
- Button held: no repeat events; the block stays in ASSERT until the debounced release, then runs the full HOLD.
- Button glitch shorter than DEBOUNCE_CYCLES: no effect.

Test Plan:
- Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
- Power-on: rst=1 for 5 cycles, then 0 -> rst_n_o=0 through edge 22 and 1 at edge 23; busy_o falls with it; cause_o=00; rst_count_o=0.
- Software reset: in RUN, pulse sw_rst_req high for 3 cycles -> rst_n_o low at the edge sampling it; HOLD starts after sw_rst_req drops; rst_n_o high 20 cycles later; cause_o=10; rst_count_o=1.
- Button debounce:
  - btn_in high for 3 cycles -> no change.
  - btn_in high for 10 cycles -> reset event; cause_o=01; rst_count_o increments once.
  - After release, rst_n_o stays low for 20 further cycles.
- Simultaneous and mid-HOLD events:
  - btn_press and sw_rst_req on the same edge -> one event, cause_o=01.
  - Button press during HOLD -> back to ASSERT, count +1, and the hold restarts from 0.
- Mid-operation pin reset and saturation:
  - After 300 software resets -> rst_count_o=255.
  - Assert rst mid-HOLD, between clock edges -> rst_n_o=0 immediately; count=0; cause=00; normal 23-edge release afterwards.
